// File: rtl/conv_result_writer_pkg.sv
// Shared constants for the convolution result writer.
// Holds the default image geometry, the derived output-frame geometry,
// the pixel saturation ceiling and the FSM state encodings.
package conv_result_writer_pkg;

  localparam int DEF_IMG_W   = 128;
  localparam int DEF_IMG_H   = 128;
  localparam int DEF_NORM_SH = 4;
  localparam int DEF_ADDR_W  = 15;

  // A valid 3x3 convolution loses one pixel on every border.
  localparam int OUT_W     = DEF_IMG_W - 2;
  localparam int OUT_H     = DEF_IMG_H - 2;
  localparam int LAST_ADDR = OUT_W * OUT_H - 1;

  localparam logic [7:0] PIX_MAX = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/conv_result_writer_pixel_normaliser.sv
// Combinational normaliser: divides the convolution sum by the kernel
// weight sum (a right shift) and clamps the quotient to an 8-bit pixel.
// Ports:
//   result  in  20  unsigned convolution sum
//   pix     out 8   normalised, saturated pixel
module pixel_normaliser
  import conv_result_writer_pkg::*;
#(
  parameter int NORM_SH = DEF_NORM_SH
) (
  input  logic [19:0] result,
  output logic [7:0]  pix
);

  function automatic logic [7:0] sat_u8(input logic [19:0] val);
    if (|val[19:8]) return PIX_MAX;
    else            return val[7:0];
  endfunction

  logic [19:0] sum;

  assign sum = result >> NORM_SH;
  assign pix = sat_u8(sum);

endmodule

// File: rtl/conv_result_writer.sv
// Output stage of the convolution datapath. Each done_conv strobe carries
// a convolution sum; it is normalised, saturated and written one cycle
// later into the output-image BRAM at the next raster address of a
// (IMG_W-2)x(IMG_H-2) frame. frame_done rises once the last pixel is written.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            arm (or restart) a frame
//   done_conv        one-cycle strobe, result valid
//   result [19:0]    unsigned convolution sum
//   wea/addra/dina   BRAM write port (registered)
//   col/row [6:0]    raster position of the write on addra
//   frame_done       level, frame complete until next start
//   overrun          sticky, strobe seen outside RUN
module conv_result_writer
  import conv_result_writer_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int NORM_SH = DEF_NORM_SH,
  parameter int ADDR_W  = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done_conv,
  input  logic [19:0]       result,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic [6:0]        col,
  output logic [6:0]        row,
  output logic              frame_done,
  output logic              overrun
);

  localparam int FRAME_W    = IMG_W - 2;
  localparam int FRAME_H    = IMG_H - 2;
  localparam int FRAME_LAST = FRAME_W * FRAME_H - 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] nxt_addr;
  logic [6:0]        nxt_col;
  logic [6:0]        nxt_row;
  logic [7:0]        pix;
  logic              last_wr;

  pixel_normaliser #(
    .NORM_SH(NORM_SH)
  ) u_norm (
    .result(result),
    .pix   (pix)
  );

  // The final pixel is on the write port this cycle; the frame closes on
  // the next edge, so any strobe arriving now has nowhere to go.
  assign last_wr = wea && (addra == ADDR_W'(FRAME_LAST));

  // nxt_* track the position of the next pixel to be written, while
  // addra/col/row keep describing the write currently (or last) issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wea        <= 1'b0;
      addra      <= '0;
      dina       <= 8'd0;
      col        <= 7'd0;
      row        <= 7'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      nxt_addr   <= '0;
      nxt_col    <= 7'd0;
      nxt_row    <= 7'd0;
    end else begin
      wea <= 1'b0;
      if (start) begin
        // start outranks a coincident strobe: it is dropped, not an overrun
        state      <= ST_RUN;
        addra      <= '0;
        col        <= 7'd0;
        row        <= 7'd0;
        frame_done <= 1'b0;
        overrun    <= 1'b0;
        nxt_addr   <= '0;
        nxt_col    <= 7'd0;
        nxt_row    <= 7'd0;
      end else begin
        case (state)
          ST_RUN: begin
            if (last_wr) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
              if (done_conv) overrun <= 1'b1;
            end else if (done_conv) begin
              wea      <= 1'b1;
              dina     <= pix;
              addra    <= nxt_addr;
              col      <= nxt_col;
              row      <= nxt_row;
              nxt_addr <= nxt_addr + ADDR_W'(1);
              if (nxt_col == 7'(FRAME_W - 1)) begin
                nxt_col <= 7'd0;
                nxt_row <= nxt_row + 7'd1;
              end else begin
                nxt_col <= nxt_col + 7'd1;
              end
            end
          end
          default: begin
            if (done_conv) overrun <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_result_writer.sv
module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        done_conv = 1'b0;
  logic [19:0] result = 20'd0;
  logic        wea;
  logic [14:0] addra;
  logic [7:0]  dina;
  logic [6:0]  col;
  logic [6:0]  row;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  localparam int OW = 126;
  localparam int OH = 126;

  conv_result_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .done_conv (done_conv),
    .result    (result),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .col       (col),
    .row       (row),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] res;
    logic [7:0]  exp_pix;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // one isolated strobe; returns at the negedge where its write is visible
  task automatic strobe(input logic [19:0] r);
    @(negedge clk);
    done_conv = 1'b1;
    result = r;
    @(negedge clk);
    done_conv = 1'b0;
  endtask

  initial begin
    int bad;
    vecs[0] = '{20'd1600,    8'd100};
    vecs[1] = '{20'd4080,    8'd255};
    vecs[2] = '{20'd4096,    8'd255};
    vecs[3] = '{20'd15,      8'd0};
    vecs[4] = '{20'd0,       8'd0};
    vecs[5] = '{20'hFFFFF,   8'd255};
    vecs[6] = '{20'd4095,    8'd255};
    vecs[7] = '{20'd16,      8'd1};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_wea", int'(wea), 0);
    chk("rst_addra", int'(addra), 0);
    chk("rst_dina", int'(dina), 0);
    chk("rst_col", int'(col), 0);
    chk("rst_row", int'(row), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // strobe while IDLE
    strobe(20'd1600);
    chk("idle_wea", int'(wea), 0);
    chk("idle_overrun", int'(overrun), 1);
    do_start();
    chk("start_clr_overrun", int'(overrun), 0);

    // normalisation table
    for (int i = 0; i < 8; i++) begin
      strobe(vecs[i].res);
      chk($sformatf("norm%0d_wea", i), int'(wea), 1);
      chk($sformatf("norm%0d_dina", i), int'(dina), int'(vecs[i].exp_pix));
      chk($sformatf("norm%0d_addra", i), int'(addra), i);
    end

    // asynchronous reset mid-RUN
    @(negedge clk);
    done_conv = 1'b1;
    result = 20'd1600;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wea", int'(wea), 0);
    chk("arst_addra", int'(addra), 0);
    chk("arst_dina", int'(dina), 0);
    chk("arst_col", int'(col), 0);
    chk("arst_row", int'(row), 0);
    done_conv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    strobe(20'd1600);
    chk("post_rst_wea", int'(wea), 0);
    chk("post_rst_overrun", int'(overrun), 1);

    // raster wrap over the first row
    do_start();
    bad = 0;
    for (int i = 0; i < 127; i++) begin
      strobe(20'd320);
      if (!(wea && addra == 15'(i) && col == 7'(i % OW) && row == 7'(i / OW) && dina == 8'd20))
        bad++;
    end
    chk("raster_bad_writes", bad, 0);
    chk("raster_addra", int'(addra), 126);
    chk("raster_col", int'(col), 0);
    chk("raster_row", int'(row), 1);

    // back-to-back strobes
    do_start();
    @(negedge clk);
    done_conv = 1'b1;
    result = 20'd48;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) done_conv = 1'b0;
      chk($sformatf("b2b%0d_wea", k), int'(wea), 1);
      chk($sformatf("b2b%0d_addra", k), int'(addra), k);
    end
    @(negedge clk);
    chk("b2b_wea_off", int'(wea), 0);

    // full frame, continuous strobes
    do_start();
    @(negedge clk);
    done_conv = 1'b1;
    result = 20'd800;
    bad = 0;
    for (int i = 0; i < OW * OH; i++) begin
      @(negedge clk);
      if (i == OW * OH - 1) done_conv = 1'b0;
      if (!(wea && addra == 15'(i) && col == 7'(i % OW) && row == 7'(i / OW) && dina == 8'd50))
        bad++;
      if (frame_done) bad++;
    end
    chk("frame_bad_writes", bad, 0);
    @(negedge clk);
    chk("frame_done", int'(frame_done), 1);
    chk("frame_wea_off", int'(wea), 0);
    chk("frame_last_addra", int'(addra), OW * OH - 1);
    chk("frame_last_col", int'(col), OW - 1);
    chk("frame_last_row", int'(row), OH - 1);
    strobe(20'd800);
    chk("extra_wea", int'(wea), 0);
    chk("extra_overrun", int'(overrun), 1);
    chk("extra_frame_done", int'(frame_done), 1);

    // restart from DONE clears status
    do_start();
    chk("restart_overrun", int'(overrun), 0);
    chk("restart_frame_done", int'(frame_done), 0);
    for (int i = 0; i < 5; i++) strobe(20'd160);
    chk("pre_restart_addra", int'(addra), 4);

    // start together with a strobe mid-frame
    @(negedge clk);
    start = 1'b1;
    done_conv = 1'b1;
    result = 20'd1600;
    @(negedge clk);
    start = 1'b0;
    done_conv = 1'b0;
    chk("restart_wea", int'(wea), 0);
    chk("restart_addra", int'(addra), 0);
    chk("restart_col", int'(col), 0);
    chk("restart_row", int'(row), 0);
    chk("restart_no_overrun", int'(overrun), 0);
    strobe(20'd1600);
    chk("restart_first_wea", int'(wea), 1);
    chk("restart_first_addra", int'(addra), 0);
    chk("restart_first_dina", int'(dina), 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
